// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 16-bit CPU controller.
package cpu_pkg;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_HLT = 3'b111;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;
  localparam logic [3:0] VSEL_MDATA = 4'b0001;
  localparam logic [3:0] VSEL_IMM   = 4'b0010;
  localparam logic [3:0] VSEL_PC    = 4'b0100;
  localparam logic [3:0] VSEL_C     = 4'b1000;
  typedef logic [4:0] state_t;
  localparam state_t S_IF1     = 5'd0;
  localparam state_t S_IF2     = 5'd1;
  localparam state_t S_UPD_PC  = 5'd2;
  localparam state_t S_DECODE  = 5'd3;
  localparam state_t S_WR_IMM  = 5'd4;
  localparam state_t S_GET_A   = 5'd5;
  localparam state_t S_GET_B   = 5'd6;
  localparam state_t S_EXEC    = 5'd7;
  localparam state_t S_WB      = 5'd8;
  localparam state_t S_ADDR    = 5'd9;
  localparam state_t S_LD_DAR  = 5'd10;
  localparam state_t S_MEM_RD1 = 5'd11;
  localparam state_t S_MEM_RD2 = 5'd12;
  localparam state_t S_GET_RD  = 5'd13;
  localparam state_t S_PASS_B  = 5'd14;
  localparam state_t S_MEM_WR  = 5'd15;
  localparam state_t S_HALT    = 5'd16;
endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// instr_decoder: splits the instruction register into fields and sign-extends immediates.
module instr_decoder (
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: fetch/decode FSM owning PC, IR and DAR; drives all datapath controls.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mdata,
  input  logic [8:0]  datapath_out,
  output logic [8:0]  mem_addr,
  output logic [1:0]  mem_cmd,
  output logic [15:0] pc,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [3:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        halted
);
  state_t state, next;
  logic [15:0] ir;
  logic [8:0] pc_q, dar;
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic is_movi, is_movr, is_alu, is_cmp, is_ldr, is_str, is_mem;

  instr_decoder u_dec (
    .ir(ir), .opcode(opcode), .op(op), .rn(rn), .rd(rd), .sh(sh), .rm(rm),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  assign is_movi = opcode == OPC_MOV && op == OP_MOVI;
  assign is_movr = opcode == OPC_MOV && op == OP_MOVR;
  assign is_alu  = opcode == OPC_ALU;
  assign is_cmp  = is_alu && op == OP_CMP;
  assign is_ldr  = opcode == OPC_LDR && op == 2'b00;
  assign is_str  = opcode == OPC_STR && op == 2'b00;
  assign is_mem  = is_ldr || is_str;

  always_comb begin
    next = S_HALT;
    case (state)
      S_IF1:     next = S_IF2;
      S_IF2:     next = S_UPD_PC;
      S_UPD_PC:  next = S_DECODE;
      S_DECODE:  next = is_movi ? S_WR_IMM : (is_alu || is_movr || is_mem) ? S_GET_A : S_HALT;
      S_WR_IMM:  next = S_IF1;
      S_GET_A:   next = is_mem ? S_ADDR : S_GET_B;
      S_GET_B:   next = S_EXEC;
      S_EXEC:    next = is_cmp ? S_IF1 : S_WB;
      S_WB:      next = S_IF1;
      S_ADDR:    next = S_LD_DAR;
      S_LD_DAR:  next = is_ldr ? S_MEM_RD1 : S_GET_RD;
      S_MEM_RD1: next = S_MEM_RD2;
      S_MEM_RD2: next = S_IF1;
      S_GET_RD:  next = S_PASS_B;
      S_PASS_B:  next = S_MEM_WR;
      S_MEM_WR:  next = S_IF1;
      default:   next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IF1;
      pc_q  <= '0;
      ir    <= '0;
      dar   <= '0;
    end else begin
      state <= next;
      if (state == S_IF2) ir <= mdata;
      if (state == S_UPD_PC) pc_q <= pc_q + 9'd1;
      if (state == S_LD_DAR) dar <= datapath_out;
    end

  // Reset holds the FSM in IF1, so the fetch READ is masked until reset_n releases.
  assign mem_cmd  = !reset_n ? CMD_NONE :
                    (state == S_IF1 || state == S_IF2 || state == S_MEM_RD1 || state == S_MEM_RD2) ? CMD_READ :
                    state == S_MEM_WR ? CMD_WRITE : CMD_NONE;
  assign mem_addr = (state == S_MEM_RD1 || state == S_MEM_RD2 || state == S_MEM_WR) ? dar : pc_q;
  assign pc       = {7'b0, pc_q};
  assign vsel     = state == S_WR_IMM ? VSEL_IMM : state == S_MEM_RD2 ? VSEL_MDATA : VSEL_C;
  assign asel     = (state == S_EXEC && (is_movr || (is_alu && op == OP_MVN))) || state == S_PASS_B;
  assign bsel     = state == S_ADDR;
  assign loada    = state == S_GET_A;
  assign loadb    = state == S_GET_B || state == S_GET_RD;
  assign loadc    = state == S_EXEC || state == S_ADDR || state == S_PASS_B;
  assign loads    = state == S_EXEC && is_cmp;
  assign ALUop    = state == S_EXEC ? op : ALU_ADD;
  assign shift    = state == S_EXEC ? sh : 2'b00;
  assign readnum  = state == S_GET_A ? rn : state == S_GET_B ? rm : state == S_GET_RD ? rd : 3'd0;
  assign writenum = state == S_WR_IMM ? rn : (state == S_WB || state == S_MEM_RD2) ? rd : 3'd0;
  assign write    = state == S_WR_IMM || state == S_WB || state == S_MEM_RD2;
  assign halted   = state == S_HALT;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: controller driving a behavioural datapath/memory, checked against an ISA-level model.
module tb_cpu_controller;
  logic clk = 0, reset_n = 1;
  logic [15:0] mdata, pc, sximm8, sximm5;
  logic [8:0] mem_addr;
  logic [1:0] mem_cmd, ALUop, shift;
  logic [3:0] vsel;
  logic asel, bsel, loada, loadb, loadc, loads, write, halted;
  logic [2:0] readnum, writenum;
  logic [15:0] a_reg, b_reg, c_reg, alu_out;
  logic z_flag;
  logic [15:0] rf [0:7];
  logic [15:0] mem [0:511];
  logic dp_clr = 0, ld_en = 0;
  logic [8:0] ld_addr = 0;
  logic [15:0] ld_data = 0;
  logic [15:0] m_rf [0:7];
  logic [15:0] m_mem [0:511];
  logic [8:0] m_pc;
  logic m_z;
  bit if1, prev_rd, h;
  int checks = 0, errors = 0;
  logic [58:0] idle;
  localparam logic [58:0] IDLE = {2'b00, 9'd0, 16'd0, 4'b1000, 12'd0, 16'd0};

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .mdata(mdata), .datapath_out(c_reg[8:0]),
    .mem_addr(mem_addr), .mem_cmd(mem_cmd), .pc(pc), .sximm8(sximm8), .sximm5(sximm5),
    .vsel(vsel), .asel(asel), .bsel(bsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .ALUop(ALUop), .shift(shift), .readnum(readnum), .writenum(writenum),
    .write(write), .halted(halted)
  );

  assign idle = {mem_cmd, mem_addr, pc, vsel, asel, bsel, loada, loadb, loadc, loads,
                 ALUop, shift, write, halted, sximm8};

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'b01:   return v << 1;
      2'b10:   return v >> 1;
      2'b11:   return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  function automatic logic [15:0] alu_f(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~b;
    endcase
  endfunction

  assign alu_out = alu_f(ALUop, asel ? 16'd0 : a_reg, bsel ? sximm5 : shf(b_reg, shift));

  // Datapath and memory environment obeying the controller's selects and enables.
  always @(posedge clk) begin
    if (dp_clr) for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
    else if (write) rf[writenum] <= vsel[0] ? mdata : vsel[1] ? sximm8 : vsel[2] ? pc : c_reg;
    if (loada) a_reg <= rf[readnum];
    if (loadb) b_reg <= rf[readnum];
    if (loadc) c_reg <= alu_out;
    if (loads) z_flag <= alu_out == 16'd0;
    if (mem_cmd == 2'b01) mdata <= mem[mem_addr];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_cmd == 2'b10) mem[mem_addr] <= c_reg;
  end

  function automatic logic [15:0] movi(input logic [2:0] n, input logic [7:0] imm);
    return {3'b110, 2'b10, n, imm};
  endfunction
  function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [2:0] n, input logic [2:0] d,
                                          input logic [1:0] s, input logic [2:0] m);
    return {3'b101, op, n, d, s, m};
  endfunction
  function automatic logic [15:0] ldr(input logic [2:0] d, input logic [2:0] n, input logic [4:0] imm);
    return {3'b011, 2'b00, n, d, imm};
  endfunction
  function automatic logic [15:0] str(input logic [2:0] d, input logic [2:0] n, input logic [4:0] imm);
    return {3'b100, 2'b00, n, d, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if1 = mem_cmd == 2'b01 && mem_addr == pc[8:0] && !prev_rd;
    prev_rd = mem_cmd == 2'b01 && mem_addr == pc[8:0];
  endtask

  // ISA-level reference: executes one instruction, reports its cycle cost and any store.
  task automatic model_step(output int cyc, output bit hlt, output bit st,
                            output logic [8:0] sa, output logic [15:0] sd);
    logic [15:0] i, b;
    logic [8:0] ea;
    logic [2:0] n, d;
    i = m_mem[m_pc];
    m_pc = (m_pc == 9'd511) ? 9'd0 : m_pc + 9'd1;
    n = i[10:8];
    d = i[7:5];
    b = shf(m_rf[i[2:0]], i[4:3]);
    ea = 9'(m_rf[n] + {{11{i[4]}}, i[4:0]});
    hlt = 0; st = 0; sa = 0; sd = 0; cyc = 0;
    case (i[15:11])
      5'b11010: begin m_rf[n] = {{8{i[7]}}, i[7:0]}; cyc = 5; end
      5'b11000: begin m_rf[d] = b; cyc = 8; end
      5'b10100: begin m_rf[d] = m_rf[n] + b; cyc = 8; end
      5'b10101: begin m_z = m_rf[n] == b; cyc = 7; end
      5'b10110: begin m_rf[d] = m_rf[n] & b; cyc = 8; end
      5'b10111: begin m_rf[d] = ~b; cyc = 8; end
      5'b01100: begin m_rf[d] = m_mem[ea]; cyc = 9; end
      5'b10000: begin m_mem[ea] = m_rf[d]; st = 1; sa = ea; sd = m_rf[d]; cyc = 10; end
      default:  hlt = 1;
    endcase
  endtask

  task automatic start_prog(input string tag);
    reset_n = 0; dp_clr = 1; ld_en = 1;
    for (int i = 0; i < 512; i++) begin
      ld_addr = 9'(i); ld_data = m_mem[i];
      @(posedge clk); #1;
    end
    ld_en = 0; dp_clr = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    m_pc = 9'd0;
    @(negedge clk);
    chk({tag, " reset idle"}, idle, IDLE);
    @(posedge clk); #1 reset_n = 1; prev_rd = 0;
    step();
  endtask

  task automatic run_instr(input string tag, output bit hlt);
    int cyc, n, wcnt, bad;
    bit st;
    logic [8:0] sa;
    logic [15:0] sd, p;
    chk({tag, " fetch"}, {if1, mem_addr}, {1'b1, m_pc});
    model_step(cyc, hlt, st, sa, sd);
    if (hlt) begin
      repeat (4) step();
      chk({tag, " halted"}, {halted, pc}, {1'b1, 7'd0, m_pc});
      bad = 0; p = pc;
      repeat (20) begin
        step();
        bad += int'(mem_cmd != 2'b00 || write || !halted || pc != p);
      end
      chk({tag, " halt idle"}, bad, 0);
      return;
    end
    n = 0; wcnt = 0;
    do begin
      step(); n++;
      if (mem_cmd == 2'b10) begin
        wcnt++;
        chk({tag, " store"}, {mem_addr, c_reg}, {sa, sd});
      end
    end while (!if1 && n < 40);
    chk({tag, " cycles"}, n, cyc);
    chk({tag, " stores"}, wcnt, int'(st));
    chk({tag, " pc"}, pc, {7'd0, m_pc});
    for (int i = 0; i < 8; i++) chk($sformatf("%s r%0d", tag, i), rf[i], m_rf[i]);
    if (cyc == 7) chk({tag, " z"}, z_flag, m_z);
  endtask

  task automatic gen_random();
    for (int i = 0; i < 512; i++) m_mem[i] = 16'($urandom);
    m_mem[0] = movi(3'd7, 8'(64 + $urandom_range(0, 55)));
    for (int k = 1; k < 30; k++)
      case ($urandom_range(0, 4))
        0: m_mem[k] = movi(3'($urandom_range(0, 6)), 8'($urandom));
        1: m_mem[k] = {3'b110, 2'b00, 3'($urandom), 3'($urandom_range(0, 6)), 2'($urandom), 3'($urandom)};
        2: m_mem[k] = ldr(3'($urandom_range(0, 6)), 3'd7, 5'($urandom));
        3: m_mem[k] = str(3'($urandom), 3'd7, 5'($urandom));
        default: m_mem[k] = enc_alu(2'($urandom), 3'($urandom), 3'($urandom_range(0, 6)), 2'($urandom), 3'($urandom));
      endcase
    m_mem[30] = 16'hE000;
  endtask

  initial begin
    #1;
    for (int i = 0; i < 512; i++) m_mem[i] = 16'd0;
    m_mem[0] = 16'hD0FD;
    m_mem[1] = movi(3'd1, 8'd7);
    m_mem[2] = movi(3'd2, 8'd5);
    m_mem[3] = enc_alu(2'b00, 3'd1, 3'd3, 2'b01, 3'd2);
    m_mem[4] = enc_alu(2'b01, 3'd1, 3'd0, 2'b00, 3'd1);
    m_mem[5] = 16'hE000;
    start_prog("p1");
    run_instr("p1 movi", h);
    chk("p1 r0 imm", rf[0], 16'hFFFD);
    repeat (3) run_instr("p1", h);
    chk("p1 add lsl", rf[3], 16'd17);
    run_instr("p1 cmp", h);
    chk("p1 z set", z_flag, 1'b1);
    run_instr("p1 halt", h);
    chk("p1 halt pc", pc, 16'd6);

    for (int i = 0; i < 512; i++) m_mem[i] = 16'd0;
    m_mem[0] = movi(3'd4, 8'd18);
    m_mem[1] = ldr(3'd5, 3'd4, 5'd2);
    m_mem[2] = ldr(3'd6, 3'd4, 5'd3);
    m_mem[3] = str(3'd6, 3'd4, 5'h1F);
    m_mem[4] = 16'hE000;
    m_mem[20] = 16'h1234;
    m_mem[21] = 16'hABCD;
    start_prog("p2");
    for (int k = 0; k < 5; k++) begin run_instr("p2", h); if (h) break; end
    chk("p2 ldr r5", rf[5], 16'h1234);
    chk("p2 str mem17", mem[17], 16'hABCD);

    for (int i = 0; i < 512; i++) m_mem[i] = 16'd0;
    m_mem[0] = movi(3'd1, 8'd3);
    m_mem[1] = 16'hD800;
    start_prog("bad");
    run_instr("bad movi", h);
    run_instr("bad enc", h);
    chk("bad enc halts", h, 1'b1);

    for (int i = 0; i < 512; i++) m_mem[i] = 16'd0;
    m_mem[0] = movi(3'd1, 8'd7);
    m_mem[1] = movi(3'd2, 8'd5);
    m_mem[2] = enc_alu(2'b00, 3'd1, 3'd3, 2'b01, 3'd2);
    m_mem[3] = 16'hE000;
    start_prog("rx");
    run_instr("rx", h);
    run_instr("rx", h);
    repeat (6) step();
    chk("rx exec reached", {loadc, write}, 2'b10);
    reset_n = 0;
    #1 chk("rx reset idle", idle, IDLE);
    @(posedge clk); @(posedge clk); #1 reset_n = 1; prev_rd = 0;
    m_pc = 9'd0;
    step();
    chk("rx no wb", rf[3], 16'd0);
    for (int k = 0; k < 4; k++) begin run_instr("rx rerun", h); if (h) break; end
    chk("rx add after reset", rf[3], 16'd17);

    for (int i = 0; i < 512; i++) m_mem[i] = movi(3'(i % 7), 8'(i & 8'h7F));
    start_prog("wrap");
    for (int k = 0; k < 512; k++) run_instr("wrap", h);
    chk("wrap pc", pc, 16'd0);
    run_instr("wrap again", h);

    for (int r = 0; r < 5; r++) begin
      gen_random();
      start_prog($sformatf("rnd%0d", r));
      for (int k = 0; k < 31; k++) begin
        run_instr($sformatf("rnd%0d.%0d", r, k), h);
        if (h) break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
